// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO peripheral responder.
// Contents:
//   - the register map offsets;
//   - the request width encoding;
//   - the STATUS bit positions;
//   - byte-lane helpers used by sub-word stores.
package mmio_pkg;

   localparam logic [4:0] OFF_DISPLAY     = 5'h00;
   localparam logic [4:0] OFF_MTIME_LO    = 5'h04;
   localparam logic [4:0] OFF_MTIME_HI    = 5'h08;
   localparam logic [4:0] OFF_MTIMECMP_LO = 5'h0C;
   localparam logic [4:0] OFF_MTIMECMP_HI = 5'h10;
   localparam logic [4:0] OFF_STATUS      = 5'h14;
   localparam logic [4:0] OFF_TXDATA      = 5'h18;
   localparam logic [4:0] OFF_UNMAPPED    = 5'h1C;

   typedef enum logic [1:0] {
      W_BYTE    = 2'b00,
      W_HALF    = 2'b01,
      W_WORD    = 2'b10,
      W_ILLEGAL = 2'b11
   } req_width_e;

   localparam int STATUS_IRQ_BIT   = 0;
   localparam int STATUS_FULL_BIT  = 1;
   localparam int STATUS_EMPTY_BIT = 2;
   localparam int STATUS_COUNT_LSB = 4;

   // Byte lanes touched by an access of the given width at the given byte offset
   function automatic logic [3:0] laneMask(input req_width_e width, input logic [1:0] addrLo);
      logic [3:0] mask;
      case (width)
         W_BYTE:  mask = 4'b0001 << addrLo;
         W_HALF:  mask = 4'b0011 << addrLo;
         default: mask = 4'b1111;
      endcase
      return mask;
   endfunction

   // Replace only the enabled byte lanes of oldVal with those of newVal
   function automatic logic [31:0] mergeLanes(input logic [31:0] oldVal, input logic [31:0] newVal,
                                              input logic [3:0] mask);
      logic [31:0] result;
      result = oldVal;
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) result[8*i +: 8] = newVal[8*i +: 8];
      end
      return result;
   endfunction

endpackage

// File: rtl/mmio_tx_fifo.sv
// Byte TX FIFO: circular buffer with an occupancy count.
// A pop frees its slot in the same cycle, so a push to a full FIFO
// is accepted when a pop happens alongside it.
// The head is forced to zero while empty so stale data never leaks out.
module mmio_tx_fifo
   import mmio_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            push_i,
   input  logic [7:0]                      push_data_i,
   input  logic                            pop_i,
   output logic                            full_o,
   output logic                            empty_o,
   output logic [$clog2(FIFO_DEPTH):0]     count_o,
   output logic [7:0]                      head_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] rdPtr_q, wrPtr_q;
   logic [CW-1:0] count_q;
   logic          pushEff, popEff;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(FIFO_DEPTH));
   assign count_o = count_q;
   assign head_o  = empty_o ? 8'h00 : mem_q[rdPtr_q];
   assign popEff  = pop_i && !empty_o;
   assign pushEff = push_i && (!full_o || popEff);

   // Pointer and occupancy bookkeeping; pointers wrap naturally at a power-of-two depth
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (pushEff) wrPtr_q <= wrPtr_q + PW'(1);
         if (popEff)  rdPtr_q <= rdPtr_q + PW'(1);
         if (pushEff && !popEff)      count_q <= count_q + CW'(1);
         else if (popEff && !pushEff) count_q <= count_q - CW'(1);
      end
   end

   // Storage needs no reset: the count alone decides what is valid
   always_ff @(posedge clk) begin
      if (pushEff) mem_q[wrPtr_q] <= push_data_i;
   end

endmodule

// File: rtl/mmio_peripheral_responder.sv
// MMIO peripheral responder on the LSU load/store path.
// Registers: DISPLAY, 64-bit mtime/mtimecmp timer, STATUS, TXDATA byte FIFO.
// Every request that hits the 32-byte window gets a registered response
// one cycle later. Any error response suppresses all side effects.
// Optional timer: define MMIO_TIMER_EN to build the timer. Without it,
// the timer offsets read 0 and ignore writes, and timer_irq is tied to 0.
module mmio_peripheral_responder
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_width,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] display_value,
   output logic        timer_irq,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [7:0]  tx_data
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   req_width_e    widthE;
   logic [2:0]    regIdx;
   logic          hit, reqErr, doWrite, doRead, fifoPush;
   logic [3:0]    laneEn;
   logic [31:0]   wdataAligned, readWord, statusWord, rdata_d;
   logic [31:0]   display_q, display_d;
   logic [31:0]   mtimeLoRd, mtimeHiRd, cmpLoRd, cmpHiRd;
   logic          fifoFull, fifoEmpty, timerIrq;
   logic [CW-1:0] fifoCount;
   logic [7:0]    fifoHead;
   logic          rspValid_q, rspErr_q;
   logic [31:0]   rspRdata_q;

   assign widthE       = req_width_e'(req_width);
   assign regIdx       = req_addr[4:2];
   assign hit          = req_valid && (req_addr[31:5] == BASE_ADDR[31:5]);
   assign laneEn       = laneMask(widthE, req_addr[1:0]);
   assign wdataAligned = req_wdata << {req_addr[1:0], 3'b000};

   // Error classification; a push into a full FIFO only fails when no pop frees a slot
   always_comb begin
      reqErr = 1'b0;
      if (widthE == W_ILLEGAL)                                   reqErr = 1'b1;
      if ((widthE == W_HALF) && req_addr[0])                     reqErr = 1'b1;
      if ((widthE == W_WORD) && (req_addr[1:0] != 2'b00))        reqErr = 1'b1;
      if (regIdx == OFF_UNMAPPED[4:2])                           reqErr = 1'b1;
      if (req_we && (regIdx == OFF_TXDATA[4:2]) && fifoFull && !tx_ready) reqErr = 1'b1;
      doWrite  = hit && req_we && !reqErr;
      doRead   = hit && !req_we && !reqErr;
      fifoPush = doWrite && (regIdx == OFF_TXDATA[4:2]);
   end

   // DISPLAY register next value with byte-lane merge on stores
   always_comb begin
      display_d = display_q;
      if (doWrite && (regIdx == OFF_DISPLAY[4:2])) display_d = mergeLanes(display_q, wdataAligned, laneEn);
   end

`ifdef MMIO_TIMER_EN
   logic [63:0] mtime_q, mtime_d, cmp_q, cmp_d;
   logic [31:0] shadow_q, shadow_d;
   logic        irq_q;

   // Timer next state: free-running increment, written lanes override it, LO loads snapshot HI
   always_comb begin
      mtime_d  = mtime_q + 64'd1;
      cmp_d    = cmp_q;
      shadow_d = shadow_q;
      if (doWrite && (regIdx == OFF_MTIME_LO[4:2]))    mtime_d[31:0]  = mergeLanes(mtime_d[31:0], wdataAligned, laneEn);
      if (doWrite && (regIdx == OFF_MTIME_HI[4:2]))    mtime_d[63:32] = mergeLanes(mtime_d[63:32], wdataAligned, laneEn);
      if (doWrite && (regIdx == OFF_MTIMECMP_LO[4:2])) cmp_d[31:0]    = mergeLanes(cmp_q[31:0], wdataAligned, laneEn);
      if (doWrite && (regIdx == OFF_MTIMECMP_HI[4:2])) cmp_d[63:32]   = mergeLanes(cmp_q[63:32], wdataAligned, laneEn);
      if (doRead && (regIdx == OFF_MTIME_LO[4:2]))     shadow_d       = mtime_q[63:32];
   end

   // Timer registers; the interrupt lags the comparison by one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtime_q  <= '0;
         cmp_q    <= '1;
         shadow_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         mtime_q  <= mtime_d;
         cmp_q    <= cmp_d;
         shadow_q <= shadow_d;
         irq_q    <= (mtime_q >= cmp_q);
      end
   end

   assign timerIrq  = irq_q;
   assign mtimeLoRd = mtime_q[31:0];
   assign mtimeHiRd = shadow_q;
   assign cmpLoRd   = cmp_q[31:0];
   assign cmpHiRd   = cmp_q[63:32];
`else
   assign timerIrq  = 1'b0;
   assign mtimeLoRd = '0;
   assign mtimeHiRd = '0;
   assign cmpLoRd   = '0;
   assign cmpHiRd   = '0;
`endif

   // STATUS word assembly; the count field holds the low four bits of the occupancy
   always_comb begin
      statusWord                                         = '0;
      statusWord[STATUS_IRQ_BIT]                         = timerIrq;
      statusWord[STATUS_FULL_BIT]                        = fifoFull;
      statusWord[STATUS_EMPTY_BIT]                       = fifoEmpty;
      statusWord[STATUS_COUNT_LSB +: 4]                  = 4'(fifoCount);
   end

   // Read mux, then right-align the addressed bytes for the LSU
   always_comb begin
      readWord = '0;
      case (regIdx)
         OFF_DISPLAY[4:2]:     readWord = display_q;
         OFF_MTIME_LO[4:2]:    readWord = mtimeLoRd;
         OFF_MTIME_HI[4:2]:    readWord = mtimeHiRd;
         OFF_MTIMECMP_LO[4:2]: readWord = cmpLoRd;
         OFF_MTIMECMP_HI[4:2]: readWord = cmpHiRd;
         OFF_STATUS[4:2]:      readWord = statusWord;
         default:              readWord = '0;
      endcase
      rdata_d = doRead ? (readWord >> {req_addr[1:0], 3'b000}) : '0;
   end

   // Response and DISPLAY registers; reset drops any in-flight response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rspValid_q <= 1'b0;
         rspErr_q   <= 1'b0;
         rspRdata_q <= '0;
         display_q  <= '0;
      end else begin
         rspValid_q <= hit;
         rspErr_q   <= hit && reqErr;
         rspRdata_q <= rdata_d;
         display_q  <= display_d;
      end
   end

   mmio_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) uTxFifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (fifoPush),
      .push_data_i (req_wdata[7:0]),
      .pop_i       (tx_ready),
      .full_o      (fifoFull),
      .empty_o     (fifoEmpty),
      .count_o     (fifoCount),
      .head_o      (fifoHead)
   );

   assign rsp_valid     = rspValid_q;
   assign rsp_err       = rspErr_q;
   assign rsp_rdata     = rspRdata_q;
   assign display_value = display_q;
   assign timer_irq     = timerIrq;
   assign tx_valid      = !fifoEmpty;
   assign tx_data       = fifoHead;

endmodule

// File: tb/tb_mmio_peripheral_responder.sv
// Directed testbench for mmio_peripheral_responder.
// Requests are driven on the falling edge and held for one full cycle.
// Responses are sampled on the next falling edge.
// Timer checks follow MMIO_TIMER_EN the same way the design does.
module tb_mmio_peripheral_responder;

   localparam logic [1:0] WB = 2'b00, WH = 2'b01, WW = 2'b10, WI = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we, tx_ready;
   logic [1:0]  req_width;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err, timer_irq, tx_valid;
   logic [31:0] rsp_rdata, display_value;
   logic [7:0]  tx_data;
   int          checks = 0;
   int          errors = 0;

   // Free-running 10-time-unit clock
   always #5 clk = ~clk;

   mmio_peripheral_responder dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_width(req_width),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .display_value(display_value), .timer_irq(timer_irq),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data)
   );

   // One request for one cycle; called at a falling edge, returns at the next one
   task automatic applyStimulus(input logic we, input logic [1:0] width, input logic [31:0] addr,
                                input logic [31:0] wdata);
      req_valid = 1'b1; req_we = we; req_width = width; req_addr = addr; req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_width = WW; req_addr = '0; req_wdata = '0;
      tx_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_err: got %b expected 0", rsp_err); end
      checks++; if (display_value !== 32'h0) begin errors++; $display("[TB] FAIL reset_display: got %h expected 0", display_value); end
      checks++; if (timer_irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", timer_irq); end
      checks++; if ({tx_valid, tx_data} !== 9'h0) begin errors++; $display("[TB] FAIL reset_tx: got %b/%h expected 0/00", tx_valid, tx_data); end
   endtask

   task automatic test_display();
      applyStimulus(1'b1, WW, 32'h0000_2000, 32'hDEAD_BEEF);
      checks++; if ({rsp_valid, rsp_err} !== 2'b10) begin errors++; $display("[TB] FAIL disp_word_rsp: got valid=%b err=%b expected 1/0", rsp_valid, rsp_err); end
      checks++; if (display_value !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL disp_word: got %h expected deadbeef", display_value); end
      applyStimulus(1'b1, WB, 32'h0000_2002, 32'h0000_0012);
      checks++; if (display_value !== 32'hDE12_BEEF) begin errors++; $display("[TB] FAIL disp_byte: got %h expected de12beef", display_value); end
      applyStimulus(1'b0, WB, 32'h0000_2001, 32'h0);
      checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h00DE_12BE}) begin errors++; $display("[TB] FAIL load_byte: got v=%b e=%b %h expected 1/0 00de12be", rsp_valid, rsp_err, rsp_rdata); end
      applyStimulus(1'b1, WH, 32'h0000_2001, 32'h0000_5555);
      checks++; if ({rsp_valid, rsp_err} !== 2'b11) begin errors++; $display("[TB] FAIL misaligned_err: got valid=%b err=%b expected 1/1", rsp_valid, rsp_err); end
      checks++; if (display_value !== 32'hDE12_BEEF) begin errors++; $display("[TB] FAIL misaligned_hold: got %h expected de12beef", display_value); end
      applyStimulus(1'b1, WI, 32'h0000_2000, 32'h1111_1111);
      checks++; if ({rsp_err, display_value} !== {1'b1, 32'hDE12_BEEF}) begin errors++; $display("[TB] FAIL illegal_width: got err=%b %h expected 1 de12beef", rsp_err, display_value); end
   endtask

   task automatic test_fifo();
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, WW, 32'h0000_2018, 32'h0000_0041 + i);
         checks++; if (rsp_err !== (i == 4)) begin errors++; $display("[TB] FAIL push_err_%0d: got %b expected %b", i, rsp_err, (i == 4)); end
      end
      applyStimulus(1'b0, WW, 32'h0000_2014, 32'h0);
      checks++; if (rsp_rdata !== 32'h0000_0042) begin errors++; $display("[TB] FAIL status_full: got %h expected 00000042", rsp_rdata); end
      applyStimulus(1'b0, WW, 32'h0000_2018, 32'h0);
      checks++; if ({rsp_err, rsp_rdata} !== 33'h0) begin errors++; $display("[TB] FAIL txdata_read: got err=%b %h expected 0 0", rsp_err, rsp_rdata); end
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if ({tx_valid, tx_data} !== {1'b1, 8'h41 + 8'(i)}) begin errors++; $display("[TB] FAIL drain_%0d: got %b/%h expected 1/%h", i, tx_valid, tx_data, 8'h41 + 8'(i)); end
         @(negedge clk);
      end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty: got %b expected 0", tx_valid); end
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, WB, 32'h0000_2018, 32'h0000_0061 + i);
      tx_ready = 1'b1;
      applyStimulus(1'b1, WB, 32'h0000_2018, 32'h0000_0065);
      tx_ready = 1'b0;
      checks++; if ({rsp_err, tx_data} !== {1'b0, 8'h62}) begin errors++; $display("[TB] FAIL full_push_pop: got err=%b head=%h expected 0/62", rsp_err, tx_data); end
      applyStimulus(1'b0, WW, 32'h0000_2014, 32'h0);
      checks++; if (rsp_rdata !== 32'h0000_0042) begin errors++; $display("[TB] FAIL status_still_full: got %h expected 00000042", rsp_rdata); end
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (tx_data !== 8'h62 + 8'(i)) begin errors++; $display("[TB] FAIL drain2_%0d: got %h expected %h", i, tx_data, 8'h62 + 8'(i)); end
         @(negedge clk);
      end
      tx_ready = 1'b0;
      applyStimulus(1'b0, WW, 32'h0000_2014, 32'h0);
      checks++; if (rsp_rdata[7:1] !== 7'b0000_010) begin errors++; $display("[TB] FAIL status_empty: got %h expected empty, count 0", rsp_rdata); end
   endtask

   task automatic test_decode();
      applyStimulus(1'b0, WW, 32'h0000_1FFC, 32'h0);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL miss_below: got %b expected 0", rsp_valid); end
      applyStimulus(1'b1, WW, 32'h0000_2020, 32'h0);
      checks++; if ({rsp_valid, display_value} !== {1'b0, 32'hDE12_BEEF}) begin errors++; $display("[TB] FAIL miss_above: got %b %h expected 0 de12beef", rsp_valid, display_value); end
      applyStimulus(1'b0, WW, 32'h0000_201C, 32'h0);
      checks++; if ({rsp_valid, rsp_err} !== 2'b11) begin errors++; $display("[TB] FAIL unmapped: got valid=%b err=%b expected 1/1", rsp_valid, rsp_err); end
   endtask

`ifdef MMIO_TIMER_EN
   task automatic test_timer();
      applyStimulus(1'b1, WW, 32'h0000_2008, 32'hFFFF_FFFF);
      applyStimulus(1'b1, WW, 32'h0000_2004, 32'hFFFF_FFFE);
      applyStimulus(1'b0, WW, 32'h0000_2004, 32'h0);
      checks++; if (rsp_rdata !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL mtime_lo: got %h expected fffffffe", rsp_rdata); end
      applyStimulus(1'b0, WW, 32'h0000_2008, 32'h0);
      checks++; if (rsp_rdata !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mtime_shadow: got %h expected ffffffff", rsp_rdata); end
      applyStimulus(1'b0, WW, 32'h0000_2004, 32'h0);
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL mtime_wrap_lo: got %h expected 0", rsp_rdata); end
      applyStimulus(1'b0, WW, 32'h0000_2008, 32'h0);
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL mtime_wrap_hi: got %h expected 0", rsp_rdata); end
      applyStimulus(1'b1, WW, 32'h0000_2010, 32'h0);
      applyStimulus(1'b1, WW, 32'h0000_200C, 32'd100);
      applyStimulus(1'b1, WW, 32'h0000_2004, 32'd90);
      repeat (10) @(negedge clk);
      checks++; if (timer_irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_early: got %b expected 0", timer_irq); end
      @(negedge clk);
      checks++; if (timer_irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_rise: got %b expected 1", timer_irq); end
      applyStimulus(1'b1, WW, 32'h0000_200C, 32'd1000);
      @(negedge clk);
      checks++; if (timer_irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_clear: got %b expected 0", timer_irq); end
   endtask
`else
   task automatic test_timer();
      applyStimulus(1'b1, WW, 32'h0000_2004, 32'h0000_1234);
      checks++; if ({rsp_valid, rsp_err} !== 2'b10) begin errors++; $display("[TB] FAIL notimer_write: got valid=%b err=%b expected 1/0", rsp_valid, rsp_err); end
      applyStimulus(1'b0, WW, 32'h0000_2004, 32'h0);
      checks++; if ({rsp_err, rsp_rdata} !== 33'h0) begin errors++; $display("[TB] FAIL notimer_lo: got err=%b %h expected 0 0", rsp_err, rsp_rdata); end
      applyStimulus(1'b0, WW, 32'h0000_200C, 32'h0);
      checks++; if ({rsp_err, rsp_rdata} !== 33'h0) begin errors++; $display("[TB] FAIL notimer_cmp: got err=%b %h expected 0 0", rsp_err, rsp_rdata); end
      applyStimulus(1'b0, WW, 32'h0000_2014, 32'h0);
      checks++; if ({timer_irq, rsp_rdata[0]} !== 2'b00) begin errors++; $display("[TB] FAIL notimer_irq: got irq=%b status0=%b expected 0/0", timer_irq, rsp_rdata[0]); end
   endtask
`endif

   task automatic test_reset_mid_op();
      tx_ready = 1'b0;
      applyStimulus(1'b1, WB, 32'h0000_2018, 32'h0000_0077);
      req_valid = 1'b1; req_we = 1'b0; req_width = WW; req_addr = 32'h0000_2000;
      #2 rst = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; rst = 1'b0;
      @(negedge clk);
      checks++; if ({rsp_valid, tx_valid} !== 2'b00) begin errors++; $display("[TB] FAIL midreset: got valid=%b tx_valid=%b expected 0/0", rsp_valid, tx_valid); end
      checks++; if (display_value !== 32'h0) begin errors++; $display("[TB] FAIL midreset_display: got %h expected 0", display_value); end
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_display();
      test_fifo();
      test_decode();
      test_timer();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
